// File: rtl/key_expansion_multi.sv
// Word-serial AES key schedule for 128/192/256-bit keys: one 32-bit schedule
// word per clock, packed into addressed 128-bit round keys.
module key_expansion_multi #(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_in_valid,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         key_in_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_addr,
  output logic         key_valid,
  output logic         key_loaded,
  output logic         key_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_e             state_q, state_d;
  logic [7:0][31:0]   key_q;
  logic [31:0]        win_q [8];
  logic [1:0]         size_q;
  logic [5:0]         i_q;
  logic [2:0]         phase_q, phase_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [127:0]       key_out_q;
  logic [3:0]         key_addr_q;
  logic               key_valid_q, key_loaded_q, key_err_q;

  logic        size_ok, accept, reject, is_run, last_w, word_lt_nk;
  logic [2:0]  nk_m1;
  logic [5:0]  last_word;
  logic [31:0] sub_in, sub_out, word_d;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    size_ok = 1'b0;
    case (key_size)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = SUPPORT_192;
      2'b10:   size_ok = SUPPORT_256;
      default: size_ok = 1'b0;
    endcase
  end

  assign accept = key_in_valid && key_in_ready && size_ok;
  assign reject = key_in_valid && key_in_ready && !size_ok;
  assign is_run = (state_q == RUN);

  always_comb begin
    nk_m1     = 3'd7;
    last_word = 6'd59;
    case (size_q)
      2'b00:   begin nk_m1 = 3'd3; last_word = 6'd43; end
      2'b01:   begin nk_m1 = 3'd5; last_word = 6'd51; end
      default: begin nk_m1 = 3'd7; last_word = 6'd59; end
    endcase
  end

  assign word_lt_nk = (i_q <= {3'b000, nk_m1});
  assign last_w     = (i_q == last_word);
  assign phase_d    = (phase_q == nk_m1) ? 3'd0 : phase_q + 3'd1;

  // win_q[0] is W[i-1]; win_q[nk-1] is W[i-Nk]. RotWord applies only at phase 0.
  assign sub_in  = (phase_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];
  assign sub_out = sub_word(sub_in);

  always_comb begin
    word_d = win_q[nk_m1] ^ win_q[0];
    rcon_d = rcon_q;
    if (word_lt_nk) begin
      word_d = key_q[3'd7 - i_q[2:0]];
    end else if (phase_q == 3'd0) begin
      word_d = win_q[nk_m1] ^ sub_out ^ {rcon_q, 24'h000000};
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end else if (nk_m1 == 3'd7 && phase_q == 3'd4) begin
      word_d = win_q[7] ^ sub_out;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = RUN;
      RUN:        if (last_w) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb key_in_ready = (state_q != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q       <= 2'b00;
      i_q          <= '0;
      phase_q      <= '0;
      rcon_q       <= 8'h01;
      key_out_q    <= '0;
      key_addr_q   <= '0;
      key_valid_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      key_addr_q  <= '0;
      key_err_q   <= reject;
      if (accept) begin
        size_q       <= key_size;
        i_q          <= '0;
        phase_q      <= '0;
        rcon_q       <= 8'h01;
        key_loaded_q <= 1'b0;
      end else if (is_run) begin
        i_q     <= i_q + 6'd1;
        phase_q <= phase_d;
        rcon_q  <= rcon_d;
        if (i_q[1:0] == 2'b11) begin
          key_valid_q <= 1'b1;
          key_addr_q  <= i_q[5:2] + 4'd1;
          key_out_q   <= {win_q[2], win_q[1], win_q[0], word_d};
        end
        if (last_w) key_loaded_q <= 1'b1;
      end
    end
  end

  // NOTE: the key capture and word window are not reset; they are always
  // written (capture on accept, words 0..Nk-1 from the key) before being read.
  always_ff @(posedge clk) begin
    if (accept) key_q <= key_in;
    if (is_run) begin
      win_q[0] <= word_d;
      for (int j = 1; j < 8; j++) win_q[j] <= win_q[j-1];
    end
  end

  assign key_out    = key_out_q;
  assign key_addr   = key_addr_q;
  assign key_valid  = key_valid_q;
  assign key_loaded = key_loaded_q;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_key_expansion_multi.sv
// Directed bench for key_expansion_multi using the FIPS-197 appendix A vectors,
// load rejection, mid-run reset and back-to-back reloads.
module tb_key_expansion_multi;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk, rst;
  logic         key_in_valid, n_key_in_valid;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         key_in_ready, key_valid, key_loaded, key_err;
  logic [127:0] key_out;
  logic [3:0]   key_addr;
  logic         n_ready, n_valid, n_loaded, n_err;
  logic [127:0] n_out;
  logic [3:0]   n_addr;

  int checks = 0;
  int errors = 0;
  int strobe_cnt, loaded_edge, err_seen, order_bad;
  logic [127:0] rk [1:15];

  key_expansion_multi dut (
    .clk(clk), .rst(rst), .key_in_valid(key_in_valid), .key_size(key_size),
    .key_in(key_in), .key_in_ready(key_in_ready), .key_out(key_out),
    .key_addr(key_addr), .key_valid(key_valid), .key_loaded(key_loaded),
    .key_err(key_err)
  );

  key_expansion_multi #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) dut_n256 (
    .clk(clk), .rst(rst), .key_in_valid(n_key_in_valid), .key_size(key_size),
    .key_in(key_in), .key_in_ready(n_ready), .key_out(n_out),
    .key_addr(n_addr), .key_valid(n_valid), .key_loaded(n_loaded),
    .key_err(n_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one load so that the following rising edge is the acceptance edge (edge 0).
  task automatic start(input logic [1:0] sz, input logic [255:0] k);
    @(negedge clk);
    key_in_valid = 1'b1;
    key_size     = sz;
    key_in       = k;
    @(posedge clk);
    #1;
    key_in_valid = 1'b0;
    key_size     = 2'b11;
  endtask

  // Samples edges 1..n_edges after acceptance; optionally pokes loads during the run.
  task automatic collect(input int n_edges, input int poke_edge);
    strobe_cnt = 0; loaded_edge = 0; err_seen = 0; order_bad = 0;
    for (int k = 1; k <= 15; k++) rk[k] = '0;
    for (int e = 1; e <= n_edges; e++) begin
      if (poke_edge > 0) begin
        key_in_valid = (e == poke_edge) || (e == poke_edge + 1);
        key_size     = (e == poke_edge) ? 2'b11 : 2'b00;
        key_in       = '1;
      end
      @(posedge clk);
      #1;
      if (key_err) err_seen++;
      if (key_valid) begin
        strobe_cnt++;
        if (int'(key_addr) != strobe_cnt || e != 4 * int'(key_addr)) order_bad++;
        if (key_addr != 4'd0) rk[key_addr] = key_out;
      end else if (key_addr != 4'd0) begin
        order_bad++;
      end
      if (key_loaded && loaded_edge == 0) loaded_edge = e;
    end
    key_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_in_valid = 1'b0; n_key_in_valid = 1'b0;
    key_size = 2'b00; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  128'(key_in_ready), 128'd1);
    check("rst_out",    key_out,            128'd0);
    check("rst_addr",   128'(key_addr),     128'd0);
    check("rst_valid",  128'(key_valid),    128'd0);
    check("rst_loaded", 128'(key_loaded),   128'd0);
    check("rst_err",    128'(key_err),      128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reserved size in IDLE: one-cycle error, stays idle.
    start(2'b11, K128);
    check("rej11_err",   128'(key_err),      128'd1);
    check("rej11_ready", 128'(key_in_ready), 128'd1);
    check("rej11_valid", 128'(key_valid),    128'd0);
    @(posedge clk);
    #1;
    check("rej11_err_drop", 128'(key_err),      128'd0);
    check("rej11_idle",     128'(key_in_ready), 128'd1);

    // 256-bit request to a build without 256 support.
    @(negedge clk);
    n_key_in_valid = 1'b1; key_size = 2'b10; key_in = K256;
    @(posedge clk);
    #1;
    n_key_in_valid = 1'b0;
    check("n256_err", 128'(n_err), 128'd1);
    strobe_cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (n_valid) strobe_cnt++;
    end
    check("n256_no_valid", 128'(strobe_cnt), 128'd0);
    check("n256_ready",    128'(n_ready),    128'd1);

    // AES-128 with loads poked during RUN (must be ignored).
    start(2'b00, K128);
    collect(46, 10);
    check("a128_strobes", 128'(strobe_cnt),  128'd11);
    check("a128_rk1",     rk[1],             K128[255:128]);
    check("a128_rk2",     rk[2],             128'ha0fafe1788542cb123a339392a6c7605);
    check("a128_rk11",    rk[11],            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a128_loaded",  128'(loaded_edge), 128'd44);
    check("a128_order",   128'(order_bad),   128'd0);
    check("a128_no_err",  128'(err_seen),    128'd0);
    check("a128_ready",   128'(key_in_ready), 128'd1);

    // Reset at edge 20 of an AES-128 run.
    start(2'b00, K128);
    collect(20, 0);
    check("mid_strobes", 128'(strobe_cnt), 128'd5);
    rst = 1'b1;
    #1;
    check("mid_ready",  128'(key_in_ready), 128'd1);
    check("mid_out",    key_out,            128'd0);
    check("mid_addr",   128'(key_addr),     128'd0);
    check("mid_valid",  128'(key_valid),    128'd0);
    check("mid_loaded", 128'(key_loaded),   128'd0);
    @(negedge clk);
    rst = 1'b0;
    collect(8, 0);
    check("mid_quiet", 128'(strobe_cnt), 128'd0);

    // AES-256 after reset.
    start(2'b10, K256);
    collect(60, 0);
    check("a256_strobes", 128'(strobe_cnt),  128'd15);
    check("a256_rk1",     rk[1],             K256[255:128]);
    check("a256_rk3",     rk[3],             128'h9ba354118e6925afa51a8b5f2067fcde);
    check("a256_rk15",    rk[15],            128'hfe4890d1e6188d0b046df344706c631e);
    check("a256_loaded",  128'(loaded_edge), 128'd60);
    check("a256_order",   128'(order_bad),   128'd0);
    check("a256_loaded_hi", 128'(key_loaded), 128'd1);

    // Back-to-back: reload AES-128 on the cycle key_loaded is first seen.
    start(2'b00, K128);
    check("b2b_loaded_drop", 128'(key_loaded), 128'd0);
    collect(44, 0);
    check("b2b_strobes", 128'(strobe_cnt),  128'd11);
    check("b2b_rk1",     rk[1],             K128[255:128]);
    check("b2b_rk2",     rk[2],             128'ha0fafe1788542cb123a339392a6c7605);
    check("b2b_rk11",    rk[11],            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("b2b_loaded",  128'(loaded_edge), 128'd44);
    check("b2b_order",   128'(order_bad),   128'd0);

    // AES-192 from DONE.
    start(2'b01, K192);
    collect(52, 0);
    check("a192_strobes", 128'(strobe_cnt),  128'd13);
    check("a192_rk2",     rk[2],             128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("a192_rk13",    rk[13],            128'he98ba06f448c773c8ecc720401002202);
    check("a192_loaded",  128'(loaded_edge), 128'd52);
    check("a192_order",   128'(order_bad),   128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expansion_multi.md
# key_expansion_multi

Word-serial AES key schedule for 128-, 192- and 256-bit cipher keys. It replaces the fixed AES-128 round-key sequencer. It accepts one cipher key per load handshake and generates one 32-bit schedule word per clock. It emits each completed 128-bit round key with a 1-based address into the round-key register file, and flags completion for the cipher datapath.

## Interface
- SUPPORT_192, default 1: accept 192-bit keys when 1. When 0, a 192 request is rejected.
- SUPPORT_256, default 1: accept 256-bit keys when 1. When 0, a 256 request is rejected.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_in_valid  in  1  load request.
- key_size  in  2  key length select:
  - 00 = 128-bit.
  - 01 = 192-bit.
  - 10 = 256-bit.
  - 11 = reserved.
- key_in  in  256  cipher key, left-aligned. Word0 = key_in[255:224]. 128-bit keys use [255:128]; 192-bit keys use [255:64].
- key_in_ready  out  1  load accepted this cycle if key_in_valid=1. High in IDLE and DONE.
- key_out  out  128  round key. Bits [127:96] = first word of the round key.
- key_addr  out  4  round-key address, 1..Nr+1. Value 0 means no key this cycle.
- key_valid  out  1  one-cycle strobe; key_out and key_addr are valid.
- key_loaded  out  1  all round keys emitted. Held high until the next accepted load.
- key_err  out  1  one-cycle pulse on a rejected load request.

## Operation
- Per-mode constants:
  - 00: Nk=4, Nr=10, 44 words.
  - 01: Nk=6, Nr=12, 52 words.
  - 10: Nk=8, Nr=14, 60 words.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on an accepted load.
  - RUN -> DONE after the last word is generated.
  - DONE -> RUN on an accepted load. Any reload from DONE is permitted.
- Accepted load: key_in_valid=1, key_in_ready=1 and key_size supported. On acceptance:
  - Capture key_in and key_size.
  - Clear the word counter i to 0 and the phase counter (i mod Nk) to 0.
  - Set the rcon register to 0x01.
  - Clear key_loaded.
- Rejected load: key_size=11, or a disabled size, while ready. Raise key_err for 1 cycle. State, outputs and registers are unchanged.
- RUN generates one word W[i] per cycle:
  - i < Nk: W[i] = captured key word i.
  - i ≥ Nk and i mod Nk = 0: W[i] = W[i-Nk] ^ SubWord(RotWord(W[i-1])) ^ {rcon, 24'h0}. rcon then updates to xtime(rcon) (shift left 1; XOR 0x1B on carry-out).
  - Nk=8 and i mod 8 = 4: W[i] = W[i-8] ^ SubWord(W[i-1]).
  - Otherwise: W[i] = W[i-Nk] ^ W[i-1].
- Storage:
  - An 8-deep × 32 shift window holds the last Nk words.
  - Four combinational S-box lookups (256-entry ROM each) implement SubWord.
  - RotWord is a left byte rotation.
- Packer:
  - Each new word shifts into a 4-word output register.
  - When (i mod 4) = 3, the block drives key_out = {W[i-3], W[i-2], W[i-1], W[i]}, key_addr = (i+1)/4 and key_valid = 1.
- After word 4(Nr+1)-1 is generated: state goes to DONE and key_loaded goes to 1.
- key_in_ready is low in RUN. key_in_valid is ignored there; no key_err is raised.

## Timing
- Reset values:
  - state = IDLE.
  - key_in_ready = 1.
  - key_out = 0.
  - key_addr = 0.
  - key_valid = 0.
  - key_loaded = 0.
  - key_err = 0.
  - rcon = 0x01.
  - Counters = 0.
- All outputs are registered except key_in_ready, which decodes from state.
- Cycle 0 is the load-acceptance edge. W[i] is produced at edge i+1.
- Round key k (1..Nr+1) is valid in the cycle after edge 4k. Round keys are strictly 4 cycles apart.
- key_loaded rises at edge 4(Nr+1), together with the final key_valid:
  - 128-bit: edge 44.
  - 192-bit: edge 52.
  - 256-bit: edge 60.
- Between strobes, key_out holds its last value, key_addr = 0 and key_valid = 0.
- Final rcon value before DONE:
  - 128-bit: 0x36 was the last used.
  - 192-bit: 0x80 last used.
  - 256-bit: 0x40 last used.
- Reload from DONE on the same edge key_loaded is observed: accepted. key_loaded drops the next cycle.
- Reset mid-RUN: the block returns immediately to the reset values. No further key_valid occurs until a new load.
- key_size is sampled only on acceptance. Changes during RUN have no effect.

## Test plan
- AES-128 (FIPS-197 A.1): key 2b7e1516 28aed2a6 abf71588 09cf4f3c, size 00.
  - Addr 1 = the key.
  - Addr 11 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 at edge 44.
  - key_loaded rises at edge 44.
- AES-192 (A.2): key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - 13 strobes.
  - Addr 13 = e98ba06f 448c773c 8ecc7204 01002202.
- AES-256 (A.3): key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - 15 strobes.
  - Addr 15 = fe4890d1 e6188d0b 046df344 706c631e.
- Rejection:
  - size 11 in IDLE -> key_err pulse, state remains IDLE.
  - With SUPPORT_256=0, size 10 -> key_err, no key_valid.
  - key_in_valid during RUN -> ignored, sequence unchanged.
- Reset mid-run: assert rst at edge 20 of an AES-128 run.
  - All outputs are 0 and ready = 1 immediately.
  - A subsequent 256-bit load produces a correct schedule.
- Back-to-back: in DONE of AES-256, load the AES-128 vector.
  - Addresses restart at 1.
  - The rcon sequence restarts at 0x01.
  - The A.1 results match.
